// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Instruction-fetch sequencer for the 5-stage RV32 pipeline.
//               Owns the fetch PC, drives a single-outstanding req/gnt/rvalid
//               instruction-memory port, applies Execute redirects, honours
//               Decode stalls and drives the IF/ID register with a valid bit.
// Ports       : clk, rst_n            - clock, synchronous active-low reset
//               PCSrcE, PCTargetE     - redirect request / target from Execute
//               StallD                - Decode stall (hold IF/ID)
//               imem_req, imem_addr   - fetch request / address
//               imem_gnt              - request accepted (req&gnt = handshake)
//               imem_rvalid, imem_rdata - response valid / instruction
//               InsD, PC_D, PC_4D, ValidD - IF/ID register contents
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_INSN   = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  PCSrcE,
  input  logic [ADDR_WIDTH-1:0] PCTargetE,
  input  logic                  StallD,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] InsD,
  output logic [ADDR_WIDTH-1:0] PC_D,
  output logic [ADDR_WIDTH-1:0] PC_4D,
  output logic                  ValidD
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] c_pc_step = ADDR_WIDTH'(4);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  r_kill;   // in-flight response belongs to a redirected-away path
  logic [DATA_WIDTH-1:0] r_buf;    // response parked while IF/ID is blocked

  logic                  w_can_load;
  logic [ADDR_WIDTH-1:0] w_pc_plus4;
  logic                  w_load_wait;
  logic                  w_load_hold;
  logic                  w_load;
  logic [DATA_WIDTH-1:0] w_load_data;

  // Request and address come straight from flops, so they are glitch-free.
  assign imem_req  = (r_state == S_REQ);
  assign imem_addr = r_pc;

  // A bubble in IF/ID may be overwritten even while Decode is stalled.
  assign w_can_load  = !StallD || !ValidD;
  assign w_pc_plus4  = r_pc + c_pc_step;
  assign w_load_wait = (r_state == S_WAIT) && imem_rvalid && !r_kill && !PCSrcE && w_can_load;
  assign w_load_hold = (r_state == S_HOLD) && !PCSrcE && w_can_load;
  assign w_load      = w_load_wait || w_load_hold;
  assign w_load_data = (r_state == S_HOLD) ? r_buf : imem_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_kill  <= 1'b0;
      r_buf   <= NOP_INSN;
      InsD    <= NOP_INSN;
      PC_D    <= '0;
      PC_4D   <= '0;
      ValidD  <= 1'b0;
    end else begin
      // ---------------- fetch control ----------------
      case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          // No handshake yet, so the address may still move on a redirect.
          if (PCSrcE) r_pc <= PCTargetE;
          if (imem_gnt) begin
            r_state <= S_WAIT;
            r_kill  <= PCSrcE;
          end
        end
        S_WAIT: begin
          if (PCSrcE) r_pc <= PCTargetE;
          if (imem_rvalid) begin
            r_kill <= 1'b0;
            if (r_kill || PCSrcE) begin
              r_state <= S_REQ;
            end else if (w_can_load) begin
              r_pc    <= w_pc_plus4;
              r_state <= S_REQ;
            end else begin
              r_buf   <= imem_rdata;
              r_state <= S_HOLD;
            end
          end else if (PCSrcE) begin
            r_kill <= 1'b1;
          end
        end
        S_HOLD: begin
          if (PCSrcE) begin
            r_pc    <= PCTargetE;
            r_state <= S_REQ;
          end else if (w_can_load) begin
            r_pc    <= w_pc_plus4;
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // ---------------- IF/ID register ----------------
      // Redirect flush wins over both a load and a Decode stall.
      if (PCSrcE) begin
        ValidD <= 1'b0;
        InsD   <= NOP_INSN;
      end else if (w_load) begin
        InsD   <= w_load_data;
        PC_D   <= r_pc;
        PC_4D  <= w_pc_plus4;
        ValidD <= 1'b1;
      end else if (!(StallD && ValidD)) begin
        ValidD <= 1'b0;
        InsD   <= NOP_INSN;
      end
    end
  end

`ifndef SYNTHESIS
  // Once raised, a request stays up with a stable address until accepted,
  // unless a redirect moves it before the handshake. Responses arriving
  // outside WAIT are tolerated and dropped (stale data after a reset).
  a_req_stable : assert property (@(posedge clk)
    (rst_n && imem_req && !imem_gnt && !PCSrcE) |=> (imem_req && $stable(imem_addr)));
`endif

endmodule
`default_nettype wire
